// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with an integrated scoreboard of per-register pending bits.
// Latency: reads are combinational (0 cycles); writes, pending updates and busy_cnt land on the next rising clk edge.
// Backpressure: iss_stall refuses an issue whose destination still has an outstanding producer (WAW); RF_BYPASS_EN adds write-to-read forwarding.
module regfile_mp_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [NR*AW-1:0]   ra,
    output logic [NR*DW-1:0]   q,
    output logic [NR-1:0]      rbusy,
    input  logic               we0,
    input  logic [AW-1:0]      wn0,
    input  logic [DW-1:0]      d0,
    input  logic               we1,
    input  logic [AW-1:0]      wn1,
    input  logic [DW-1:0]      d1,
    input  logic               iss_v,
    input  logic [AW-1:0]      iss_rd,
    output logic               iss_stall,
    output logic [AW:0]        busy_cnt
);

    localparam int NREG = 1 << AW;

    typedef logic [AW:0] cnt_t;

    // The read-port mux and rbusy vector are only defined for 1..4 ports.
    generate
        if (NR < 1 || NR > 4) begin : g_bad_nr
            $error("regfile_mp_sb: NR=%0d is outside the supported range 1..4", NR);
        end
    endgenerate

    logic [DW-1:0]   rf [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_nxt;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    logic wr0;
    logic wr1;
    logic wr0_eff;
    logic iss_exempt;
    logic iss_acc;
    cnt_t n_rise;
    cnt_t n_fall;

    // Qualify the write-back ports and the issue request. r0 is exempt when hard-wired, port 1 wins a
    // same-register collision, and nothing counts as performed while reset is held.
    always_comb begin
        wr0        = clrn && we0 && !((ZERO_REG != 0) && (wn0 == '0));
        wr1        = clrn && we1 && !((ZERO_REG != 0) && (wn1 == '0));
        wr0_eff    = wr0 && !(wr1 && (wn1 == wn0));
        iss_exempt = (ZERO_REG != 0) && (iss_rd == '0);
        iss_stall  = iss_v && !iss_exempt && pending[iss_rd];
        iss_acc    = clrn && iss_v && !iss_exempt && !pending[iss_rd];
    end

    // Next pending vector: write-backs clear, an accepted issue sets; set is applied last so a new
    // producer survives a same-cycle write-back to the same register.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wr0_eff) begin
            clr_mask[wn0] = 1'b1;
        end
        if (wr1) begin
            clr_mask[wn1] = 1'b1;
        end
        if (iss_acc) begin
            set_mask[iss_rd] = 1'b1;
        end
        pend_nxt = (pending & ~clr_mask) | set_mask;
    end

    // Count true 0->1 and 1->0 transitions so busy_cnt tracks popcount(pending) exactly.
    always_comb begin
        n_rise = '0;
        n_fall = '0;
        for (int r = 0; r < NREG; r++) begin
            n_rise = n_rise + cnt_t'(pend_nxt[r] & ~pending[r]);
            n_fall = n_fall + cnt_t'(pending[r] & ~pend_nxt[r]);
        end
    end

    // Register storage: both write-back ports update on the rising edge, port 0 suppressed on collision.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else begin
            if (wr0_eff) begin
                rf[wn0] <= d0;
            end
            if (wr1) begin
                rf[wn1] <= d1;
            end
        end
    end

    // Scoreboard state: pending bits and the running count of outstanding producers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pending  <= '0;
            busy_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            busy_cnt <= busy_cnt + n_rise - n_fall;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] q_i;
        logic          rbusy_i;

        assign addr = ra[i*AW +: AW];

        // Read mux for one port: stored value and pending bit, optionally overridden by same-cycle
        // write-back data; a hard-wired r0 always reads as zero and never busy.
        always_comb begin
            q_i     = rf[addr];
            rbusy_i = pending[addr];
`ifdef RF_BYPASS_EN
            if (wr1 && (wn1 == addr)) begin
                q_i     = d1;
                rbusy_i = iss_acc && (iss_rd == addr);
            end else if (wr0_eff && (wn0 == addr)) begin
                q_i     = d0;
                rbusy_i = iss_acc && (iss_rd == addr);
            end
`endif
            if ((ZERO_REG != 0) && (addr == '0)) begin
                q_i     = '0;
                rbusy_i = 1'b0;
            end
        end

        assign q[i*DW +: DW] = q_i;
        assign rbusy[i]      = rbusy_i;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
`timescale 1ns/1ps
module tb_regfile_mp_sb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int ZR   = 1;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              clrn;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  q;
    logic [NR-1:0]     rbusy;
    logic              we0, we1;
    logic [AW-1:0]     wn0, wn1;
    logic [DW-1:0]     d0, d1;
    logic              iss_v;
    logic [AW-1:0]     iss_rd;
    logic              iss_stall;
    logic [AW:0]       busy_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: architectural register contents and the set of outstanding producers.
    logic [DW-1:0] mem  [NREG];
    bit            pend [NREG];
    bit            in_reset;

    always #5 clk = ~clk;

    regfile_mp_sb #(.DW(DW), .AW(AW), .NR(NR), .ZERO_REG(ZR)) dut (
        .clk(clk), .clrn(clrn), .ra(ra), .q(q), .rbusy(rbusy),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .iss_v(iss_v), .iss_rd(iss_rd), .iss_stall(iss_stall), .busy_cnt(busy_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wr_ok(input logic we, input logic [AW-1:0] wn);
        return !in_reset && we && !(ZR != 0 && wn == 0);
    endfunction

    function automatic bit iss_ok();
        return !in_reset && iss_v && !(ZR != 0 && iss_rd == 0) && !pend[iss_rd];
    endfunction

    function automatic bit exp_stall();
        return iss_v && !(ZR != 0 && iss_rd == 0) && pend[iss_rd];
    endfunction

    function automatic logic [DW-1:0] exp_q(input logic [AW-1:0] a);
        if (ZR != 0 && a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (wr_ok(we1, wn1) && wn1 == a) return d1;
        if (wr_ok(we0, wn0) && wn0 == a) return d0;
`endif
        return mem[a];
    endfunction

    function automatic bit exp_rbusy(input logic [AW-1:0] a);
        if (ZR != 0 && a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if ((wr_ok(we1, wn1) && wn1 == a) || (wr_ok(we0, wn0) && wn0 == a))
            return iss_ok() && iss_rd == a;
`endif
        return pend[a];
    endfunction

    function automatic int popc();
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(pend[r]);
        return n;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            mem[r]  = '0;
            pend[r] = 1'b0;
        end
    endtask

    task automatic apply(input logic w0, input logic [AW-1:0] n0, input logic [DW-1:0] v0,
                         input logic w1, input logic [AW-1:0] n1, input logic [DW-1:0] v1,
                         input logic iv, input logic [AW-1:0] ir,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        we0 = w0; wn0 = n0; d0 = v0;
        we1 = w1; wn1 = n1; d1 = v1;
        iss_v = iv; iss_rd = ir;
        ra = {a1, a0};
    endtask

    // Compare every output against the model, slightly after the inputs settle.
    task automatic check_all(input string tag);
        #1;
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s q%0d", tag, i), 64'(q[i*DW +: DW]), 64'(exp_q(ra[i*AW +: AW])));
            chk($sformatf("%s rbusy%0d", tag, i), 64'(rbusy[i]), 64'(exp_rbusy(ra[i*AW +: AW])));
        end
        chk({tag, " iss_stall"}, 64'(iss_stall), 64'(exp_stall()));
        chk({tag, " busy_cnt"}, 64'(busy_cnt), 64'(popc()));
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = iss_ok();
        if (wr_ok(we0, wn0) && !(wr_ok(we1, wn1) && wn1 == wn0)) begin
            mem[wn0]  = d0;
            pend[wn0] = 1'b0;
        end
        if (wr_ok(we1, wn1)) begin
            mem[wn1]  = d1;
            pend[wn1] = 1'b0;
        end
        if (acc) pend[iss_rd] = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_cycle(input string tag);
        apply($urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 1), AW'($urandom_range(0, 15)),
              AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
        check_all(tag);
        tick();
    endtask

    initial begin
        in_reset = 1'b1;
        model_reset();
        clrn = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_all("reset");
        chk("reset busy_cnt const", 64'(busy_cnt), 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        in_reset = 1'b0;

        // Write r5, read it back next cycle; write to r0 is discarded.
        apply(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        check_all("wr5");
        tick();
        apply(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 5, 0);
        check_all("rd5");
        chk("rd5 const", 64'(q[DW-1:0]), 64'hDEADBEEF);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        check_all("rd0");
        chk("r0 stays 0", 64'(q[2*DW-1:DW]), 64'd0);

        // Collision on r7: port 1 wins.
        apply(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7);
        check_all("coll");
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        check_all("coll rd");
        chk("coll r7", 64'(q[DW-1:0]), 64'h22);

        // Issue r3, WAW stall on re-issue, write-back clears.
        apply(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        check_all("iss3");
        tick();
        apply(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        check_all("reiss3");
        chk("reiss3 stall", 64'(iss_stall), 64'd1);
        chk("reiss3 cnt", 64'(busy_cnt), 64'd1);
        chk("reiss3 rbusy", 64'(rbusy[0]), 64'd1);
        tick();
        apply(0, 0, 0, 1, 3, 32'hABCD, 0, 0, 3, 0);
        check_all("wb3");
        chk("wb3 cnt before", 64'(busy_cnt), 64'd1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        check_all("wb3 after");
        chk("wb3 rbusy", 64'(rbusy[0]), 64'd0);
        chk("wb3 cnt", 64'(busy_cnt), 64'd0);

        // Issue and write r9 in the same cycle: the new producer keeps it pending.
        apply(1, 9, 32'h99, 0, 0, 0, 1, 9, 9, 0);
        check_all("iw9");
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        check_all("iw9 after");
        chk("iw9 q", 64'(q[DW-1:0]), 64'h99);
        chk("iw9 rbusy", 64'(rbusy[0]), 64'd1);
        chk("iw9 cnt", 64'(busy_cnt), 64'd1);
        apply(0, 0, 0, 1, 9, 32'h999, 0, 0, 9, 0);
        check_all("clr9");
        tick();

        // Same-cycle write and read of r4.
        apply(1, 4, 32'h33, 0, 0, 0, 0, 0, 0, 0);
        check_all("pre4");
        tick();
        apply(1, 4, 32'h55, 0, 0, 0, 0, 0, 4, 0);
        check_all("byp4");
`ifdef RF_BYPASS_EN
        chk("byp4 q fwd", 64'(q[DW-1:0]), 64'h55);
`else
        chk("byp4 q old", 64'(q[DW-1:0]), 64'h33);
`endif
        chk("byp4 rbusy", 64'(rbusy[0]), 64'd0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        check_all("post4");
        chk("post4 q", 64'(q[DW-1:0]), 64'h55);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) rand_cycle("rand");

        // Reset in the middle of traffic, with no clock edge in between.
        apply(1, 6, 32'h1234, 1, 8, 32'h5678, 1, 10, 6, 8);
        #2;
        clrn = 1'b0;
        in_reset = 1'b1;
        model_reset();
        check_all("midrst");
        chk("midrst q0", 64'(q[DW-1:0]), 64'd0);
        chk("midrst q1", 64'(q[2*DW-1:DW]), 64'd0);
        chk("midrst rbusy", 64'(rbusy), 64'd0);
        chk("midrst cnt", 64'(busy_cnt), 64'd0);
        tick();
        clrn = 1'b1;
        in_reset = 1'b0;
        for (int n = 0; n < 100; n++) rand_cycle("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
